game_tick_sched: RTL
====================

Name: game_tick_sched

Overview:
- Schedules all game-state updates for the grid controller so they happen only during the blanking window after each frame is drawn.
- Latches single-cycle key events and produces gravity drops from a frame counter.
- Issues one command at a time to the grid controller over a valid/ack handshake, in fixed priority order.
- Sits between the key-press event blocks, the VGA controller's draw_finish pulse and the grid controller.

Parameters:
- GRAVITY_FRAMES, 30, frames between gravity drops (1..63).
- WINDOW_CYCLES, 1600, number of vga_clk cycles the update window stays open after draw_finish (1..4095).
- LINES_PER_LEVEL, 10, line clears per level step (used only with the optional feature).
- MIN_GRAVITY_FRAMES, 4, floor for the gravity period (used only with the optional feature).

Ports:
- vga_clk  in  1  25 MHz system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_keys  in  4  single-cycle key pulses: [0] up/rotate, [1] down, [2] left, [3] right.
- draw_finish  in  1  single-cycle pulse at the end of frame drawing.
- game_over  in  1  level; high while the game is halted.
- line_clear  in  1  single-cycle pulse per cleared row.
- cmd_ack  in  1  grid controller accepts the presented command.
- cmd_valid  out  1  a command is presented.
- cmd_code  out  3  1=rotate, 2=left, 3=right, 4=soft drop, 5=gravity; 0 when cmd_valid is low.
- window_open  out  1  update window active.
- level  out  4  current speed level.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - cmd_valid=0, cmd_code=0, window_open=0, level=0.
  - All pending flags cleared; frame and window counters =0; gravity period =GRAVITY_FRAMES; state IDLE.
- Pending flags: rot, left, right, down, grav.
  - A key pulse sets its flag. Repeated pulses before service collapse to a single pending flag.
  - A flag clears on the cycle its command is acked.
  - A pulse arriving in the same cycle as the ack of that same code leaves the flag set.
- Window:
  - draw_finish sampled at edge t makes window_open high from t+1 for exactly WINDOW_CYCLES cycles.
  - draw_finish while the window is open reloads the count to full.
- Gravity:
  - Frame counter (6-bit) increments on each draw_finish.
  - When the counter equals period-1 on a draw_finish, grav is set and the counter returns to 0.
  - An acked soft drop (code 4) resets the frame counter to 0.
  - If a code-4 ack and a gravity-causing draw_finish occur in the same cycle, the ack wins: counter goes to 0 and grav is not set.
- Priority: rot > left > right > down > grav.
- FSM states:
  - IDLE: window closed. Go to ARB when window_open rises.
  - ARB: window open. If any flag is set and game_over=0, register cmd_valid=1 and cmd_code of the highest-priority flag on the next edge, then go to ISSUE. If the window closes, go to IDLE.
  - ISSUE: hold cmd_valid and cmd_code stable until cmd_ack. On ack, drive cmd_valid=0 the following cycle and go to ARB if the window is open, else IDLE.
- Handshake rules:
  - Minimum one cycle with cmd_valid low between commands.
  - Latency: cmd_valid rises at the earliest 1 cycle after window_open rises.
  - cmd_ack while cmd_valid=0 is ignored.
  - A command in flight when the window closes stays valid until acked; no new command is issued until the next window.
- game_over=1:
  - All pending flags are cleared and held clear; key and gravity events are ignored.
  - Frame counter is held at 0.
  - Any in-flight command still completes its handshake.
  - Release resumes normal counting.
- Reset mid-handshake drops cmd_valid immediately. The grid controller must tolerate a missing ack.

Optional Feature:
- Macro: TETRIS_LEVEL_SPEEDUP_EN.
- Defined:
  - A line counter counts line_clear pulses up to LINES_PER_LEVEL-1, then wraps.
  - On each wrap, level increments (saturating at 15) and the gravity period decrements by 1 (floor MIN_GRAVITY_FRAMES).
  - The new period applies from the next frame count.
  - line_clear is ignored while game_over=1.
- Undefined: line_clear is ignored, level is constant 0, and the period is fixed at GRAVITY_FRAMES.

Test Plan:
- Reset with WINDOW_CYCLES=8: pulse draw_finish -> window_open high exactly 8 cycles starting the next cycle. No cmd_valid, since no flags are pending.
- op_keys=4'b1101 pulsed before draw_finish, ack 2 cycles after each cmd_valid -> codes issued in order 1,2,3 within one window, each separated by at least one low cycle of cmd_valid.
- GRAVITY_FRAMES=3, no keys, immediate acks -> code 5 issued in the window after every 3rd draw_finish. Soft-drop ack in frame 2 -> next gravity command delayed to 3 frames after that ack.
- Hold cmd_ack low past window close -> cmd_valid/cmd_code stay stable. Ack in blanking -> no new command until the next draw_finish.
- game_over=1 with left pending and code 4 in flight -> in-flight command completes after ack, left is discarded, no gravity while high.
- With TETRIS_LEVEL_SPEEDUP_EN, LINES_PER_LEVEL=2, GRAVITY_FRAMES=5, MIN_GRAVITY_FRAMES=4 -> 2 line_clear pulses give level=1 and period 4. 2 more give level=2 with period still 4.

Source files
------------

// File: rtl/game_tick_sched.sv
// game_tick_sched: gates game-state updates into the blanking window after each frame,
// latches key pulses and gravity ticks as pending flags, and issues one command at a time
// to the grid controller over a valid/ack handshake (rot > left > right > down > grav).
// Optional build macro: TETRIS_LEVEL_SPEEDUP_EN enables line-clear driven level/speed-up.
module game_tick_sched #(
  parameter int unsigned GRAVITY_FRAMES     = 30,
  parameter int unsigned WINDOW_CYCLES      = 1600,
  parameter int unsigned LINES_PER_LEVEL    = 10,
  parameter int unsigned MIN_GRAVITY_FRAMES = 4
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic [3:0] op_keys,
  input  logic       draw_finish,
  input  logic       game_over,
  input  logic       line_clear,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       window_open,
  output logic [3:0] level
);

  localparam logic [11:0] WinLoad  = 12'(WINDOW_CYCLES);
  localparam logic [5:0]  GravInit = 6'(GRAVITY_FRAMES);
  localparam logic [2:0]  CodeDrop = 3'd4;

  typedef enum logic [1:0] {StIdle, StArb, StIssue} state_e;

  state_e      state_q;
  logic [11:0] win_cnt_q, win_cnt_d;
  logic [5:0]  frame_cnt_q;
  logic [5:0]  period;
  // Pending flags, bit i holds the request for command code i+1.
  logic [4:0]  pend_q, pend_d;
  logic [4:0]  key_set, ack_clr;
  logic [2:0]  next_code;
  logic        ack_fire, drop_ack, grav_evt;

  assign ack_fire = (state_q == StIssue) && cmd_ack;
  assign drop_ack = ack_fire && (cmd_code == CodeDrop);
  // An acked soft drop restarts the frame count, so it also suppresses a coincident tick.
  // >= keeps the counter bounded if the period shrinks below the current count.
  assign grav_evt = draw_finish && !game_over && !drop_ack &&
                    (frame_cnt_q >= period - 6'd1);

  // Pending flag update: acks clear, pulses set (a same-cycle pulse wins over the ack).
  always_comb begin
    key_set = {grav_evt, op_keys[1], op_keys[3], op_keys[2], op_keys[0]};
    ack_clr = '0;
    for (int i = 0; i < 5; i++) begin
      ack_clr[i] = ack_fire && (cmd_code == 3'(i + 1));
    end
    pend_d = game_over ? 5'd0 : ((pend_q & ~ack_clr) | key_set);
  end

  // Fixed-priority pick of the next command code.
  always_comb begin
    next_code = 3'd0;
    if      (pend_q[0]) next_code = 3'd1;
    else if (pend_q[1]) next_code = 3'd2;
    else if (pend_q[2]) next_code = 3'd3;
    else if (pend_q[3]) next_code = 3'd4;
    else if (pend_q[4]) next_code = 3'd5;
  end

  // Window countdown; draw_finish (re)loads the full count.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (draw_finish)             win_cnt_d = WinLoad;
    else if (win_cnt_q != 12'd0) win_cnt_d = win_cnt_q - 12'd1;
  end

  // Window counter, registered window flag and pending flags.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= 12'd0;
      window_open <= 1'b0;
      pend_q      <= 5'd0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      window_open <= (win_cnt_d != 12'd0);
      pend_q      <= pend_d;
    end
  end

  // Frame counter driving gravity ticks; held at zero while the game is halted.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 6'd0;
    end else if (game_over || drop_ack) begin
      frame_cnt_q <= 6'd0;
    end else if (draw_finish) begin
      frame_cnt_q <= grav_evt ? 6'd0 : frame_cnt_q + 6'd1;
    end
  end

  // Command FSM with registered handshake outputs.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (window_open) state_q <= StArb;
        end
        StArb: begin
          if (!window_open) begin
            state_q <= StIdle;
          end else if ((next_code != 3'd0) && !game_over) begin
            cmd_valid <= 1'b1;
            cmd_code  <= next_code;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          // A command outliving the window still completes; the next one waits for a window.
          if (cmd_ack) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 3'd0;
            state_q   <= window_open ? StArb : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TETRIS_LEVEL_SPEEDUP_EN
  localparam logic [7:0] LineWrap = 8'(LINES_PER_LEVEL - 1);
  localparam logic [5:0] GravMin  = 6'(MIN_GRAVITY_FRAMES);

  logic [7:0] line_cnt_q;
  logic [3:0] level_q;
  logic [5:0] period_q;

  // Line clears step the level and shorten the gravity period down to its floor.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q <= 8'd0;
      level_q    <= 4'd0;
      period_q   <= GravInit;
    end else if (line_clear && !game_over) begin
      if (line_cnt_q >= LineWrap) begin
        line_cnt_q <= 8'd0;
        if (level_q != 4'd15)   level_q  <= level_q + 4'd1;
        if (period_q > GravMin) period_q <= period_q - 6'd1;
      end else begin
        line_cnt_q <= line_cnt_q + 8'd1;
      end
    end
  end

  assign level  = level_q;
  assign period = period_q;
`else
  logic unused_level_cfg;

  assign unused_level_cfg = line_clear | (LINES_PER_LEVEL == 0) | (MIN_GRAVITY_FRAMES == 0);
  assign level            = 4'd0;
  assign period           = GravInit;
`endif

endmodule
